// File: rtl/ads_dual_reader.sv
// Capture front-end for one dual-channel simultaneous-sampling serial ADC: CONVST pulse, conversion wait, dual-lane SPI read.
// Optional build macro ADS_TEST_RAMP_EN replaces the captured samples with an internal test ramp.
module ads_dual_reader #(
  parameter int DATA_W      = 16,
  parameter int SCLK_HALF   = 2,
  parameter int CONVST_W    = 2,
  parameter int CONV_CYCLES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              trig,
  output logic              adc_convst,
  output logic              adc_cs_n,
  output logic              adc_sclk,
  input  logic              adc_sdoa,
  input  logic              adc_sdob,
  output logic [DATA_W-1:0] Ch0_Data,
  output logic [DATA_W-1:0] Ch1_Data,
  output logic              Ch0_Data_en,
  output logic              Ch1_Data_en,
  output logic              busy,
  output logic [7:0]        overrun_cnt
);

  localparam int CNT_MAX = (CONVST_W > CONV_CYCLES)
                         ? ((CONVST_W > SCLK_HALF) ? CONVST_W : SCLK_HALF)
                         : ((CONV_CYCLES > SCLK_HALF) ? CONV_CYCLES : SCLK_HALF);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, CONV, WAIT, SHIFT, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [BIT_W-1:0]  bit_cnt, bit_nx;
  logic              sclk_nx;
  logic              shift_en;
  logic              load;
  logic [DATA_W-1:0] sr0, sr1;
`ifdef ADS_TEST_RAMP_EN
  logic [DATA_W-1:0] ramp;
`endif

  assign busy = (state != IDLE);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    bit_nx   = bit_cnt;
    sclk_nx  = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: if (trig && enable) begin
        state_nx = CONV;
        cnt_nx   = '0;
      end
      CONV: if (cnt == CNT_W'(CONVST_W - 1)) begin
        state_nx = WAIT;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
      WAIT: if (cnt == CNT_W'(CONV_CYCLES - 1)) begin
        state_nx = SHIFT;
        cnt_nx   = '0;
        bit_nx   = '0;
      end else begin
        cnt_nx = cnt + CNT_W'(1);
      end
      SHIFT: begin
        // adc_sclk itself is the phase flag: low half, then high half of each bit period.
        sclk_nx = adc_sclk;
        if (cnt == CNT_W'(SCLK_HALF - 1)) begin
          cnt_nx  = '0;
          sclk_nx = ~adc_sclk;
          if (!adc_sclk) begin
            shift_en = 1'b1;
          end else if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            state_nx = DONE;
          end else begin
            bit_nx = bit_cnt + BIT_W'(1);
          end
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        load     = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_cnt     <= '0;
      adc_convst  <= 1'b0;
      adc_cs_n    <= 1'b1;
      adc_sclk    <= 1'b0;
      sr0         <= '0;
      sr1         <= '0;
      Ch0_Data    <= '0;
      Ch1_Data    <= '0;
      Ch0_Data_en <= 1'b0;
      Ch1_Data_en <= 1'b0;
      overrun_cnt <= '0;
`ifdef ADS_TEST_RAMP_EN
      ramp        <= '0;
`endif
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      bit_cnt    <= bit_nx;
      // Pins are registered copies of the next state so they never glitch.
      adc_convst <= (state_nx == CONV);
      adc_cs_n   <= (state_nx != SHIFT);
      adc_sclk   <= sclk_nx;
      if (shift_en) begin
        sr0 <= {sr0[DATA_W-2:0], adc_sdoa};
        sr1 <= {sr1[DATA_W-2:0], adc_sdob};
      end
      Ch0_Data_en <= load;
      Ch1_Data_en <= load;
      if (load) begin
`ifdef ADS_TEST_RAMP_EN
        Ch0_Data <= ramp;
        Ch1_Data <= ~ramp;
        ramp     <= ramp + DATA_W'(1);
`else
        Ch0_Data <= sr0;
        Ch1_Data <= sr1;
`endif
      end
      if (trig && (state != IDLE) && (overrun_cnt != 8'hFF))
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ads_dual_reader.sv
// Directed self-checking bench for ads_dual_reader with a behavioural dual-lane serial ADC model.
module tb_ads_dual_reader;

  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              trig = 1'b0;
  logic              adc_convst, adc_cs_n, adc_sclk;
  logic              adc_sdoa, adc_sdob;
  logic [DATA_W-1:0] Ch0_Data, Ch1_Data;
  logic              Ch0_Data_en, Ch1_Data_en, busy;
  logic [7:0]        overrun_cnt;

  ads_dual_reader dut (
    .clk(clk), .rst(rst), .enable(enable), .trig(trig),
    .adc_convst(adc_convst), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .adc_sdoa(adc_sdoa), .adc_sdob(adc_sdob),
    .Ch0_Data(Ch0_Data), .Ch1_Data(Ch1_Data),
    .Ch0_Data_en(Ch0_Data_en), .Ch1_Data_en(Ch1_Data_en),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ADC model: MSB presented when CS_n falls, next bit after each SCLK falling edge.
  logic [15:0] pat_a = 16'hA5C3;
  logic [15:0] pat_b = 16'h3C5A;
  int falls = 0;
  always @(negedge adc_sclk or posedge adc_cs_n)
    if (adc_cs_n) falls <= 0;
    else          falls <= falls + 1;
  always_comb begin
    adc_sdoa = 1'b0;
    adc_sdob = 1'b0;
    if (falls < 16) begin
      adc_sdoa = pat_a[15 - falls];
      adc_sdob = pat_b[15 - falls];
    end
  end

`ifdef ADS_TEST_RAMP_EN
  function automatic logic [15:0] exp0(input int n); return 16'(n);  endfunction
  function automatic logic [15:0] exp1(input int n); return ~16'(n); endfunction
`else
  function automatic logic [15:0] exp0(input int n); return 16'hA5C3; endfunction
  function automatic logic [15:0] exp1(input int n); return 16'h3C5A; endfunction
`endif

  // Cycle counter plus a negedge monitor that checks every output word and tallies pin activity.
  int pcyc = 0;
  always @(posedge clk) pcyc++;

  int n_done = 0, en_cnt = 0, last_en_cyc = -1;
  int convst_hi = 0, csn_lo = 0, sclk_rise = 0;
  logic sclk_prev = 1'b0;
  logic [15:0] last0 = '0, last1 = '0;

  always @(negedge clk) begin
    if (rst) begin
      n_done = 0;
      last0  = '0;
      last1  = '0;
    end else if (Ch0_Data_en || Ch1_Data_en) begin
      check("en_pair", {Ch0_Data_en, Ch1_Data_en}, 2'b11);
      check("ch0_data", Ch0_Data, exp0(n_done));
      check("ch1_data", Ch1_Data, exp1(n_done));
      last0 = exp0(n_done);
      last1 = exp1(n_done);
      n_done++;
      en_cnt++;
      last_en_cyc = pcyc;
    end
    if (adc_convst) convst_hi++;
    if (!adc_cs_n)  csn_lo++;
    if (adc_sclk && !sclk_prev) sclk_rise++;
    sclk_prev = adc_sclk;
  end

  task automatic goto(input int target);
    while (pcyc < target) @(negedge clk);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, s_conv, s_cs, s_sc, s_en;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_convst", adc_convst, 0);
    check("rst_cs_n",   adc_cs_n,   1);
    check("rst_sclk",   adc_sclk,   0);
    check("rst_ch0",    Ch0_Data,   0);
    check("rst_ch1",    Ch1_Data,   0);
    check("rst_en",     {Ch0_Data_en, Ch1_Data_en}, 0);
    check("rst_busy",   busy,       0);
    check("rst_ovr",    overrun_cnt, 0);
    enable = 1'b1;

    // Single transaction: latency and pin timing.
    s_conv = convst_hi; s_cs = csn_lo; s_sc = sclk_rise; s_en = en_cnt;
    t0 = pcyc;
    pulse_trig();
    goto(t0 + 40);
    check("busy_mid", busy, 1);
    goto(t0 + 77);
    check("en_early", Ch0_Data_en, 0);
    goto(t0 + 78);
    check("en_lat", Ch0_Data_en, 1);
    goto(t0 + 79);
    check("en_one_cycle", Ch0_Data_en, 0);
    goto(t0 + 100);
    check("convst_cycles", convst_hi - s_conv, 2);
    check("csn_low_cycles", csn_lo - s_cs, 64);
    check("sclk_rises", sclk_rise - s_sc, 16);
    check("en_count1", en_cnt - s_en, 1);
    check("latency1", last_en_cyc - t0, 78);
    check("busy_idle", busy, 0);
    check("sclk_idle", adc_sclk, 0);

    // Triggers during CONV/WAIT, SHIFT and DONE are dropped; the first idle one is taken.
    s_en = en_cnt;
    t0 = pcyc;
    pulse_trig();
    goto(t0 + 5);  pulse_trig();
    goto(t0 + 40); pulse_trig();
    goto(t0 + 77); pulse_trig();
    goto(t0 + 78);
    check("ovr_en", Ch0_Data_en, 1);
    check("ovr_cnt3", overrun_cnt, 3);
    goto(t0 + 79);
    t1 = pcyc;
    pulse_trig();
    goto(t1 + 78);
    check("accept_en", Ch0_Data_en, 1);
    goto(t1 + 100);
    check("ovr_cnt3_after", overrun_cnt, 3);
    check("en_count2", en_cnt - s_en, 2);
    check("latency2", last_en_cyc - t1, 78);
    check("hold_ch0", Ch0_Data, last0);
    check("hold_ch1", Ch1_Data, last1);

    // Trigger held high for 300 cycles drives the overrun counter into saturation.
    trig = 1'b1;
    repeat (300) @(negedge clk);
    trig = 1'b0;
    goto(pcyc + 100);
    check("ovr_sat", overrun_cnt, 255);
    check("sat_idle", busy, 0);

    // Reset in the middle of SHIFT aborts the transaction.
    t0 = pcyc;
    pulse_trig();
    goto(t0 + 40);
    check("shift_cs_n", adc_cs_n, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cs_n",  adc_cs_n, 1);
    check("mid_rst_sclk",  adc_sclk, 0);
    check("mid_rst_convst", adc_convst, 0);
    check("mid_rst_ch0",   Ch0_Data, 0);
    check("mid_rst_ch1",   Ch1_Data, 0);
    check("mid_rst_en",    {Ch0_Data_en, Ch1_Data_en}, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_ovr",   overrun_cnt, 0);
    rst = 1'b0;
    s_en = en_cnt;
    goto(pcyc + 90);
    check("no_en_after_rst", en_cnt - s_en, 0);
    t0 = pcyc;
    pulse_trig();
    goto(t0 + 100);
    check("rst_recover_en", en_cnt - s_en, 1);
    check("latency3", last_en_cyc - t0, 78);

    // enable low: trigger ignored, nothing on the pins, not an overrun.
    enable = 1'b0;
    s_conv = convst_hi; s_cs = csn_lo; s_sc = sclk_rise; s_en = en_cnt;
    pulse_trig();
    goto(pcyc + 100);
    check("dis_convst", convst_hi - s_conv, 0);
    check("dis_cs",     csn_lo - s_cs, 0);
    check("dis_sclk",   sclk_rise - s_sc, 0);
    check("dis_en",     en_cnt - s_en, 0);
    check("dis_ovr",    overrun_cnt, 0);

    // enable dropped mid-transaction: the transaction still completes on time.
    enable = 1'b1;
    t0 = pcyc;
    pulse_trig();
    goto(t0 + 20);
    enable = 1'b0;
    goto(t0 + 78);
    check("drop_en_lat", Ch0_Data_en, 1);
    goto(t0 + 100);
    check("latency4", last_en_cyc - t0, 78);

    // Third transaction since the mid-shift reset (ramp value 2 in the ramp build).
    enable = 1'b1;
    s_en = en_cnt;
    t0 = pcyc;
    pulse_trig();
    goto(t0 + 100);
    check("en_count_last", en_cnt - s_en, 1);
    check("n_done_since_rst", n_done, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ads_dual_reader.md
Name: ads_dual_reader

Overview:
- Front-end capture block for one dual-channel simultaneous-sampling serial ADC (ads1 or ads2). Instantiated twice.
- On each start trigger: pulses CONVST, waits the conversion time, then clocks both channels out on two serial data lines (SDOA = ch0, SDOB = ch1).
- Presents each result as a 16-bit word with a one-cycle enable, in the Chx_Data / Chx_Data_en form consumed by the filter.

Parameters:
- DATA_W, 16, bits per channel word, shifted MSB first.
- SCLK_HALF, 2, clk cycles per SCLK half-period (>=1).
- CONVST_W, 2, clk cycles CONVST is held high (>=1).
- CONV_CYCLES, 10, clk cycles between CONVST falling and CS_n falling (>=1).

Ports:
- clk in 1: system clock, 50 MHz.
- rst in 1: synchronous, active-high reset.
- enable in 1: 1 = triggers accepted; 0 = triggers ignored.
- trig in 1: one-cycle sample-start pulse from the rate generator.
- adc_convst out 1: conversion start to the ADC.
- adc_cs_n out 1: ADC chip select, active low.
- adc_sclk out 1: serial clock; idles low.
- adc_sdoa in 1: serial data for ch0.
- adc_sdob in 1: serial data for ch1.
- Ch0_Data out DATA_W: ch0 sample.
- Ch1_Data out DATA_W: ch1 sample.
- Ch0_Data_en out 1: one-cycle valid for Ch0_Data.
- Ch1_Data_en out 1: one-cycle valid for Ch1_Data.
- busy out 1: high whenever the FSM is not in IDLE.
- overrun_cnt out 8: saturating count of triggers dropped while busy.

Behaviour:
- Reset, synchronous, active-high. Wins over everything, including an in-flight transaction. Next cycle:
  - FSM = IDLE.
  - adc_convst = 0, adc_cs_n = 1, adc_sclk = 0.
  - Ch0_Data = Ch1_Data = 0.
  - Both enables = 0, busy = 0, overrun_cnt = 0.
  - Shift registers and counters cleared.
- IDLE: if trig && enable, go to CONV. Otherwise stay.
- CONV: adc_convst = 1 for exactly CONVST_W cycles, then go to WAIT.
- WAIT: adc_convst = 0, adc_cs_n = 1 for CONV_CYCLES cycles, then go to SHIFT.
- SHIFT:
  - adc_cs_n = 0.
  - DATA_W SCLK periods, each SCLK_HALF cycles low then SCLK_HALF cycles high.
  - On each clk edge where adc_sclk goes 0->1, shift adc_sdoa into the ch0 register and adc_sdob into the ch1 register, MSB first.
  - After the last high phase, adc_sclk returns to 0; go to DONE.
- DONE (1 cycle):
  - adc_cs_n = 1.
  - Load Ch0_Data / Ch1_Data from the shift registers.
  - Assert Ch0_Data_en and Ch1_Data_en together for exactly 1 cycle.
  - Go to IDLE.
- Outputs hold their value between enables.
- Latency: the enables assert LAT = 1 + CONVST_W + CONV_CYCLES + 2*DATA_W*SCLK_HALF + 1 cycles after the trig cycle. This is 78 with defaults.
- trig while busy (any state except IDLE):
  - Trigger is dropped; current transaction is unaffected.
  - overrun_cnt increments and saturates at 255.
- trig in the same cycle DONE returns to IDLE: dropped, counted as overrun. The FSM is not in IDLE in that cycle.
- enable deasserted mid-transaction: the transaction completes normally. Only new starts are blocked.
- trig while enable = 0 and IDLE: ignored, not counted.
- SCLK maximum frequency = clk / (2*SCLK_HALF). SCLK never glitches; only registered outputs drive ADC pins.

Optional Feature:
- Macro ADS_TEST_RAMP_EN.
- Defined:
  - An internal DATA_W-bit ramp, reset to 0, increments by 1 at each DONE after it is used.
  - At DONE: Ch0_Data = ramp, Ch1_Data = ~ramp. Serial data is discarded.
  - ADC pin activity and timing are unchanged.
- Undefined: ramp logic absent; outputs carry ADC data.

Test Plan:
- Defaults; ADC model drives SDOA = 0xA5C3, SDOB = 0x3C5A MSB first, changing on SCLK falling edge. One trig -> enables high at cycle 78 after trig; Ch0_Data = 0xA5C3, Ch1_Data = 0x3C5A; adc_convst high 2 cycles; CS_n low for exactly 64 cycles; 16 SCLK rising edges.
- Three trig pulses 5, 40, 77 cycles after the first -> all dropped, overrun_cnt = 3, single output. A trig at cycle 79 is accepted.
- 300 trigs while busy -> overrun_cnt saturates at 255.
- rst asserted during SHIFT (cycle 40) -> next cycle CS_n = 1, SCLK = 0, outputs 0, no enable. A new trig then yields a correct 0xA5C3 / 0x3C5A.
- enable = 0: trig ignored, no pin activity, overrun_cnt unchanged. enable dropped at cycle 20 of a transaction -> transaction still completes at cycle 78.
- ADS_TEST_RAMP_EN defined, 3 trigs spaced 100 cycles -> Ch0 = 0, 1, 2 and Ch1 = 0xFFFF, 0xFFFE, 0xFFFD.
